// File: rtl/router_pkg.sv
// Shared types and helpers for the four-port router: direction encoding,
// flit geometry and the destination-field decode.
package router_pkg;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_S = 2'd1,
        DIR_E = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    localparam int FLIT_W   = 10;
    localparam int DEST_W   = 2;
    localparam int DEST_LSB = FLIT_W - DEST_W;

    // Takes only the destination field so it works for any flit width.
    function automatic dir_t dest_of(input logic [DEST_W-1:0] dest_field);
        return dir_t'(dest_field);
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: searches from i_ptr upward (mod 4) and
// grants the first requester, only when the output is enabled.
module rr_arbiter4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    input  logic       i_en,
    output logic [3:0] o_gnt,
    output logic [1:0] o_idx
);

    logic       w_found;
    logic [1:0] w_cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = i_ptr;
        w_found = 1'b0;
        w_cand  = i_ptr;
        for (int k = 0; k < 4; k++) begin
            w_cand = i_ptr + 2'(k);
            if (i_en && !w_found && i_req[w_cand]) begin
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
                w_found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_switch_alloc.sv
// Switch allocator and registered output stage for the N/S/E/W router:
// per-output round-robin arbitration gated by downstream credits.
module router_switch_alloc #(
    parameter int FLIT_W  = router_pkg::FLIT_W,
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] nty,
    input  logic [FLIT_W-1:0] sty,
    input  logic [FLIT_W-1:0] ety,
    input  logic [FLIT_W-1:0] wty,
    input  logic [3:0]        in_vld,
    output logic [3:0]        in_rdy,
    output logic [FLIT_W-1:0] nxt,
    output logic [FLIT_W-1:0] sxt,
    output logic [FLIT_W-1:0] ext,
    output logic [FLIT_W-1:0] wxt,
    output logic [3:0]        out_vld,
    input  logic [3:0]        cr_ret,
    output logic              cr_err
);

    import router_pkg::*;

    localparam int CW = $clog2(CREDITS + 1);

    logic [3:0][FLIT_W-1:0] w_flit;
    dir_t                   w_dest [4];
    logic [3:0][3:0]        w_req;      // [output][input]
    logic [3:0][3:0]        w_gnt;      // [output][input]
    logic [3:0][1:0]        w_idx;
    logic [3:0]             w_any;

    logic [3:0][FLIT_W-1:0] r_out;
    logic [3:0]             r_vld;
    logic [3:0][1:0]        r_rr;
    logic [3:0][CW-1:0]     r_credit;
    logic                   r_err;

    assign w_flit = {wty, ety, sty, nty};

    for (genvar i = 0; i < 4; i++) begin : g_dec
        assign w_dest[i] = dest_of(w_flit[i][FLIT_W-1 -: DEST_W]);
    end

    always_comb begin
        w_req = '0;
        for (int o = 0; o < 4; o++) begin
            for (int i = 0; i < 4; i++) begin
                w_req[o][i] = in_vld[i] && (w_dest[i] == dir_t'(o));
            end
        end
    end

    for (genvar o = 0; o < 4; o++) begin : g_arb
        rr_arbiter4 u_arb (
            .i_req (w_req[o]),
            .i_ptr (r_rr[o]),
            .i_en  (r_credit[o] != '0),
            .o_gnt (w_gnt[o]),
            .o_idx (w_idx[o])
        );
        assign w_any[o] = |w_gnt[o];
    end

    // Each input targets one output, so OR-ing the grant columns is safe.
    always_comb begin
        in_rdy = '0;
        if (!rst) begin
            for (int o = 0; o < 4; o++) begin
                in_rdy = in_rdy | w_gnt[o];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
            r_vld <= '0;
            r_rr  <= '0;
            r_err <= 1'b0;
            for (int o = 0; o < 4; o++) begin
                r_credit[o] <= CW'(CREDITS);
            end
        end else begin
            for (int o = 0; o < 4; o++) begin
                r_vld[o] <= w_any[o];
                if (w_any[o]) begin
                    r_out[o] <= w_flit[w_idx[o]];
                    r_rr[o]  <= w_idx[o] + 2'd1;
                end
                // Grant and return together cancel; a surplus return saturates and flags.
                case ({w_any[o], cr_ret[o]})
                    2'b10: r_credit[o] <= r_credit[o] - CW'(1);
                    2'b01: begin
                        if (r_credit[o] == CW'(CREDITS)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_credit[o] <= r_credit[o] + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign nxt     = r_out[0];
    assign sxt     = r_out[1];
    assign ext     = r_out[2];
    assign wxt     = r_out[3];
    assign out_vld = r_vld;
    assign cr_err  = r_err;

endmodule

// File: doc/router_switch_alloc.md
# router_switch_alloc

Per-cycle switch allocator and output stage for the four-port (N/S/E/W) router. It sits after the input pipeline stage, which delivers 10-bit flits on `nty/sty/ety/wty`. For each output port it decides which input flit crosses the crossbar, using round-robin fairness and credit-based flow control toward the downstream buffer. It drives the registered outputs `nxt/sxt/ext/wxt`.

## Interface
- `FLIT_W`, default 10: flit width.
  - Bits [FLIT_W-1:FLIT_W-2] are the destination port.
  - Bits [FLIT_W-3:0] are the payload.
- `CREDITS`, default 4: downstream buffer depth per output, which is also the initial credit count.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `nty`, `sty`, `ety`, `wty` in FLIT_W each: head flit from the N/S/E/W inputs.
- `in_vld` in 4: flit valid per input, bit order [0]=N, [1]=S, [2]=E, [3]=W.
- `in_rdy` out 4: flit accepted this cycle, one bit per input.
- `nxt`, `sxt`, `ext`, `wxt` out FLIT_W each: registered flit to the N/S/E/W outputs.
- `out_vld` out 4: output flit valid, one-cycle pulse per transfer.
- `cr_ret` in 4: credit return pulse per output (one downstream slot freed).
- `cr_err` out 1: sticky flag, set when a credit is returned while the counter is already at CREDITS.

## Operation
- **Destination decode:** 00=N, 01=S, 10=E, 11=W.
  - Input i requests output `dest(flit_i)` when `in_vld[i]=1`.
  - U-turns (dest equal to arrival port) are legal and get no special handling.
- **Eligibility:** output o is eligible only when `credit[o] > 0`. Requests to an ineligible output are not granted and stay pending; the input holds its flit and valid.
- **Arbitration:** one round-robin arbiter per output with a 2-bit pointer `rr[o]`.
  - Candidates are searched in the order rr[o], rr[o]+1, … mod 4.
  - The first requesting input found wins.
  - Each input requests exactly one output, so no input ever gets two grants.
- **Handshake:** `in_rdy[i]` is combinational and is 1 iff input i was granted this cycle. A transfer occurs when `in_vld[i] & in_rdy[i]`.
- **On grant of input i to output o, at the next edge:**
  - The output flit register takes `flit_i`.
  - `out_vld[o]` is 1 for exactly one cycle.
  - `credit[o]` decrements.
  - `rr[o]` becomes (i+1) mod 4.
- **Non-granting outputs:** `rr[o]` is unchanged, `out_vld[o]=0`, and the output flit register holds its previous value.
- **Credit update:** `credit[o]` next = credit − grant + `cr_ret[o]`.
  - Grant and return in the same cycle leave the count unchanged.
  - Return at CREDITS with no simultaneous grant: count saturates at CREDITS and `cr_err` is set.
  - `cr_err` stays set until reset.
- **Counter width:** `$clog2(CREDITS+1)`. The counter never underflows, because a grant requires credit > 0.

## Timing
- **Latency:** grant cycle t → flit on the output port with `out_vld` at t+1.
  - Throughput is one flit per output per cycle while credit lasts.
- **Credit return timing:** a credit returned at cycle t is usable for a grant at cycle t+1. There is no same-cycle return-to-grant bypass.
- **Reset values:**
  - Output flits: all 0.
  - `out_vld`: 0.
  - `in_rdy`: forced to 0 while `rst=1`.
  - `rr[*]`: 0, so N has priority.
  - `credit[*]`: CREDITS.
  - `cr_err`: 0.
- **Reset mid-operation:** in-flight output registers are discarded, and no transfer completes in a cycle where `rst=1`.
- **Simultaneous requests:** four inputs targeting four distinct outputs are all granted in the same cycle.

## Structure
- Shared package `router_pkg` holds:
  - the direction enum `dir_t` (N=0, S=1, E=2, W=3);
  - `FLIT_W`;
  - the destination field position;
  - the `dest_of()` decode function.
- Sub-module `rr_arbiter4`:
  - Inputs: 4-bit request, 2-bit pointer, enable (credit > 0).
  - Outputs: one-hot grant and grant index.
  - Instantiated once per output.
- The top level holds the request matrix, credit counters, output registers, pointer update and error flag.

## Test plan
1. **Reset:** after reset, all outputs are 0, credits are 4 and `cr_err=0`.
   - Drive N `in_vld` with flit 0x2A5 (dest E).
   - Expect `in_rdy=0001`, and `ext=0x2A5` with `out_vld=0100` one cycle later.
2. **Contention:** all four inputs hold flits to S (dest 01) continuously, with no credit returns.
   - Expect grants in order N, S, E, W, one per cycle, on four consecutive cycles.
   - Expect no grant in the fifth cycle (credit 0).
3. **Credit stall and resume:** from the state of scenario 2, pulse `cr_ret[1]` once.
   - Expect exactly one grant, to N (pointer wrapped), one cycle after the pulse, then a stall again.
4. **Parallel traffic:** N→E, S→W, E→N, W→S in the same cycle.
   - Expect `in_rdy=1111`, and the next cycle `out_vld=1111` with each flit on its correct output.
5. **Credit edge cases:**
   - A grant and a `cr_ret` to the same output in one cycle leave the credit unchanged.
   - `cr_ret[0]` with N credit at 4 and no grant sets `cr_err` to 1, and it stays 1 until `rst`.
6. **Reset mid-stream:** assert `rst` for one cycle in the middle of scenario 2.
   - Expect `out_vld=0` the cycle after reset, credits restored to 4, and the next grant going to N.
